// File: rtl/universal_shift_register.sv
// universal_shift_register
//
// WIDTH-bit register with eight operations selected by mode: hold, logical
// shift right/left, rotate right/left, parallel load, arithmetic shift right
// and clear. A saturating counter tracks the shift operations executed since
// the last load or clear. done pulses for one cycle when that count first
// reaches WIDTH, which marks a complete serial frame.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-low reset
//   en      in   operation enable; register and counter hold when low
//   mode    in   [2:0] operation select
//   sin_r   in   serial input entering at the MSB on a right shift
//   sin_l   in   serial input entering at the LSB on a left shift
//   d       in   [WIDTH-1:0] parallel load data
//   q       out  [WIDTH-1:0] register contents
//   sout_r  out  q[0]       (combinational)
//   sout_l  out  q[WIDTH-1] (combinational)
//   cnt     out  [CW-1:0] shifts since last load/clear, saturating at WIDTH
//   done    out  registered one-cycle frame-complete pulse

module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHR   = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_ROR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_LOAD  = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_t;

    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    cnt_next;
    logic             done_next;
    logic             is_shift;

    always_comb begin
        q_next    = q;
        cnt_next  = cnt;
        done_next = 1'b0;
        is_shift  = 1'b0;

        if (en) begin
            case (mode_t'(mode))
                MODE_HOLD: begin
                    q_next = q;
                end
                MODE_SHR: begin
                    q_next   = {sin_r, q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                MODE_SHL: begin
                    q_next   = {q[WIDTH-2:0], sin_l};
                    is_shift = 1'b1;
                end
                MODE_ROR: begin
                    q_next   = {q[0], q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                MODE_ROL: begin
                    q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
                    is_shift = 1'b1;
                end
                MODE_LOAD: begin
                    q_next   = d;
                    cnt_next = '0;
                end
                MODE_ASR: begin
                    q_next   = {q[WIDTH-1], q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                MODE_CLEAR: begin
                    q_next   = '0;
                    cnt_next = '0;
                end
                default: begin
                    q_next = q;
                end
            endcase

            // The counter saturates at WIDTH; done fires only on the
            // WIDTH-1 -> WIDTH transition, never on saturated shifts.
            if (is_shift && (cnt != CNT_FULL)) begin
                cnt_next  = cnt + 1'b1;
                done_next = (cnt == CNT_LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            q    <= q_next;
            cnt  <= cnt_next;
            // done is rewritten every edge, so a pulse always clears at the
            // following edge even when en is low.
            done <= done_next;
        end
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

    logic       clk;
    logic       rst;

    // WIDTH=4 instance
    logic       en;
    logic [2:0] mode;
    logic       sin_r;
    logic       sin_l;
    logic [3:0] d;
    logic [3:0] q;
    logic       sout_r;
    logic       sout_l;
    logic [2:0] cnt;
    logic       done;

    // WIDTH=8 instance
    logic       en8;
    logic [2:0] mode8;
    logic       sin_r8;
    logic       sin_l8;
    logic [7:0] d8;
    logic [7:0] q8;
    logic       sout_r8;
    logic       sout_l8;
    logic [3:0] cnt8;
    logic       done8;

    int checks = 0;
    int errors = 0;

    universal_shift_register #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
        .d(d), .q(q), .sout_r(sout_r), .sout_l(sout_l), .cnt(cnt), .done(done)
    );

    universal_shift_register #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .mode(mode8), .sin_r(sin_r8), .sin_l(sin_l8),
        .d(d8), .q(q8), .sout_r(sout_r8), .sout_l(sout_l8), .cnt(cnt8), .done(done8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic st4(input string tag, input logic [3:0] eq, input logic [2:0] ec, input logic ed);
        chk({tag, ".q"},    64'(q),    64'(eq));
        chk({tag, ".cnt"},  64'(cnt),  64'(ec));
        chk({tag, ".done"}, 64'(done), 64'(ed));
    endtask

    logic [7:0] exp_sl8;

    initial begin
        rst = 1'b0; en = 1'b0; mode = 3'b000; sin_r = 1'b0; sin_l = 1'b0; d = 4'h0;
        en8 = 1'b0; mode8 = 3'b000; sin_r8 = 1'b0; sin_l8 = 1'b0; d8 = 8'h00;

        // Reset state
        #12;
        st4("reset", 4'b0000, 3'd0, 1'b0);
        chk("reset.sout_r", 64'(sout_r), 64'd0);
        chk("reset.sout_l", 64'(sout_l), 64'd0);
        chk("reset.q8", 64'(q8), 64'h00);
        rst = 1'b1;

        // Load then logical shift right
        en = 1'b1; mode = 3'b101; d = 4'b1011; cyc();
        st4("shr.load", 4'b1011, 3'd0, 1'b0);
        mode = 3'b001; sin_r = 1'b0;
        chk("shr.sout_r0", 64'(sout_r), 64'd1); cyc(); st4("shr.s1", 4'b0101, 3'd1, 1'b0);
        chk("shr.sout_r1", 64'(sout_r), 64'd1); cyc(); st4("shr.s2", 4'b0010, 3'd2, 1'b0);
        chk("shr.sout_r2", 64'(sout_r), 64'd0); cyc(); st4("shr.s3", 4'b0001, 3'd3, 1'b0);
        chk("shr.sout_r3", 64'(sout_r), 64'd1); cyc(); st4("shr.s4", 4'b0000, 3'd4, 1'b1);
        mode = 3'b000; cyc(); st4("shr.hold", 4'b0000, 3'd4, 1'b0);

        // Rotate right, including a saturated fifth rotate
        mode = 3'b101; d = 4'b1001; cyc(); st4("ror.load", 4'b1001, 3'd0, 1'b0);
        mode = 3'b011;
        cyc(); st4("ror.r1", 4'b1100, 3'd1, 1'b0);
        cyc(); st4("ror.r2", 4'b0110, 3'd2, 1'b0);
        cyc(); st4("ror.r3", 4'b0011, 3'd3, 1'b0);
        cyc(); st4("ror.r4", 4'b1001, 3'd4, 1'b1);
        cyc(); st4("ror.r5", 4'b1100, 3'd4, 1'b0);

        // Arithmetic shift right then shift left, sharing the counter
        mode = 3'b101; d = 4'b1000; cyc(); st4("asr.load", 4'b1000, 3'd0, 1'b0);
        mode = 3'b110;
        cyc(); st4("asr.a1", 4'b1100, 3'd1, 1'b0);
        cyc(); st4("asr.a2", 4'b1110, 3'd2, 1'b0);
        mode = 3'b010; sin_l = 1'b1;
        cyc(); st4("asr.shl", 4'b1101, 3'd3, 1'b0);
        chk("asr.sout_l", 64'(sout_l), 64'd1);

        // Enable gating and load priority at the would-be final shift
        en = 1'b1; mode = 3'b101; d = 4'b0101; cyc(); st4("en.load", 4'b0101, 3'd0, 1'b0);
        mode = 3'b001; sin_r = 1'b0;
        cyc(); st4("en.s1", 4'b0010, 3'd1, 1'b0);
        en = 1'b0; mode = 3'b111; d = 4'b1111;
        cyc(); st4("en.off1", 4'b0010, 3'd1, 1'b0);
        en = 1'b1; mode = 3'b001;
        cyc(); st4("en.s2", 4'b0001, 3'd2, 1'b0);
        en = 1'b0; mode = 3'b101;
        cyc(); st4("en.off2", 4'b0001, 3'd2, 1'b0);
        en = 1'b1; mode = 3'b001;
        cyc(); st4("en.s3", 4'b0000, 3'd3, 1'b0);
        mode = 3'b101; d = 4'b0110;
        cyc(); st4("en.loadprio", 4'b0110, 3'd0, 1'b0);

        // Asynchronous reset mid-frame
        mode = 3'b101; d = 4'b1111; cyc(); st4("rst.load", 4'b1111, 3'd0, 1'b0);
        mode = 3'b010; sin_l = 1'b0;
        cyc(); st4("rst.s1", 4'b1110, 3'd1, 1'b0);
        cyc(); st4("rst.s2", 4'b1100, 3'd2, 1'b0);
        #2 rst = 1'b0;
        #1 st4("rst.async", 4'b0000, 3'd0, 1'b0);
        #2 rst = 1'b1;
        mode = 3'b001; sin_r = 1'b1;
        cyc(); st4("rst.p1", 4'b1000, 3'd1, 1'b0);
        cyc(); st4("rst.p2", 4'b1100, 3'd2, 1'b0);
        cyc(); st4("rst.p3", 4'b1110, 3'd3, 1'b0);
        cyc(); st4("rst.p4", 4'b1111, 3'd4, 1'b1);
        en = 1'b0;
        cyc(); st4("rst.enoff", 4'b1111, 3'd4, 1'b0);

        // Rotate left and clear
        en = 1'b1; mode = 3'b101; d = 4'b1001; cyc(); st4("rol.load", 4'b1001, 3'd0, 1'b0);
        mode = 3'b100;
        cyc(); st4("rol.r1", 4'b0011, 3'd1, 1'b0);
        mode = 3'b111;
        cyc(); st4("rol.clear", 4'b0000, 3'd0, 1'b0);
        en = 1'b0;

        // WIDTH=8 shift left of 8'hA5
        en8 = 1'b1; mode8 = 3'b101; d8 = 8'hA5; cyc();
        chk("w8.load.q", 64'(q8), 64'hA5);
        chk("w8.load.cnt", 64'(cnt8), 64'd0);
        mode8 = 3'b010; sin_l8 = 1'b0;
        exp_sl8 = 8'b1010_0101; // expected sout_l sequence, first bit at MSB
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("w8.sout_l%0d", i), 64'(sout_l8), 64'(exp_sl8[7-i]));
            cyc();
            chk($sformatf("w8.cnt%0d", i), 64'(cnt8), 64'(i + 1));
            chk($sformatf("w8.done%0d", i), 64'(done8), 64'(i == 7));
        end
        chk("w8.final.q", 64'(q8), 64'h00);
        mode8 = 3'b000;
        cyc();
        chk("w8.after.done", 64'(done8), 64'd0);
        chk("w8.after.cnt", 64'(cnt8), 64'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
